// File: rtl/lcd_spi_pkg.sv
// lcd_spi_pkg: definitions shared by the LCD SPI receiver and the LCD driver.
//   - ST7789-style command opcodes used on the link
//   - byte-level decoder state encoding
//   - param_len(): number of parameter bytes a command takes
package lcd_spi_pkg;

  // Command opcodes.
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  // Byte decoder states.
  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_PARAM  = 3'd1,
    S_PIX_HI = 3'd2,
    S_PIX_LO = 3'd3,
    S_SKIP   = 3'd4
  } rx_state_e;

  // Number of parameter bytes collected for a command (0 = none tracked).
  function automatic logic [2:0] param_len(input logic [7:0] cmd);
    logic [2:0] len;
    case (cmd)
      CMD_CASET, CMD_RASET:   len = 3'd4;
      CMD_MADCTL, CMD_COLMOD: len = 3'd1;
      default:                len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/lcd_spi_rx_if.sv
// lcd_spi_rx_if: 4-wire LCD SPI link (mode 0, MSB first).
//   sclk : serial clock, idle low
//   cs_n : chip select, active low
//   dc   : 0 = command byte, 1 = data/parameter byte
//   mosi : serial data
// master modport drives the link (LCD driver / testbench),
// slave modport receives it (panel model).
interface lcd_spi_rx_if;
  logic sclk;
  logic cs_n;
  logic dc;
  logic mosi;

  modport master (output sclk, output cs_n, output dc, output mosi);
  modport slave  (input sclk, input cs_n, input dc, input mosi);
endinterface

// File: rtl/lcd_spi_rx_byte.sv
// lcd_spi_rx_byte: byte framer for the LCD SPI receiver.
// Synchronizes the four SPI inputs into clk, detects rising sclk edges while
// cs_n is low and assembles MSB-first bytes.
// Ports:
//   clk, resetn        system clock, async active-low reset
//   spi_sclk/cs_n/dc/mosi  raw (asynchronous) SPI inputs
//   byte_rdy           1-cycle pulse when a full byte has been received
//   rx_byte            received byte (valid with byte_rdy)
//   byte_dc            dc level sampled with the 8th bit
//   frame_err_set      1-cycle pulse when cs_n rises with a partial byte
module lcd_spi_rx_byte #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_dc,
  input  logic       spi_mosi,
  output logic       byte_rdy,
  output logic [7:0] rx_byte,
  output logic       byte_dc,
  output logic       frame_err_set
);

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] dc_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_prev_r;
  logic [6:0]             shift_r;
  logic [2:0]             bit_cnt_r;

  logic sclk_s;
  logic cs_n_s;
  logic dc_s;
  logic mosi_s;
  logic sclk_rise_s;

  // All four inputs go through equal-depth chains so mosi/dc stay aligned
  // with the sclk edge that samples them.
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_n_s      = cs_sync_r[SYNC_STAGES-1];
  assign dc_s        = dc_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;

  // Input synchronizer chains and sclk edge history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      dc_sync_r   <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], spi_dc};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_r <= sclk_s;
    end
  end

  // Shift register, bit counter and byte/framing-error strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_r       <= 7'd0;
      bit_cnt_r     <= 3'd0;
      byte_rdy      <= 1'b0;
      rx_byte       <= 8'd0;
      byte_dc       <= 1'b0;
      frame_err_set <= 1'b0;
    end else begin
      byte_rdy      <= 1'b0;
      frame_err_set <= 1'b0;
      if (cs_n_s) begin
        // Deselect drops any partial byte; a non-zero count means the
        // master cut a byte short.
        if (bit_cnt_r != 3'd0) begin
          frame_err_set <= 1'b1;
        end
        bit_cnt_r <= 3'd0;
      end else if (sclk_rise_s) begin
        if (bit_cnt_r == 3'd7) begin
          byte_rdy  <= 1'b1;
          rx_byte   <= {shift_r, mosi_s};
          byte_dc   <= dc_s;
          bit_cnt_r <= 3'd0;
        end else begin
          shift_r   <= {shift_r[5:0], mosi_s};
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: receive side of a 4-wire ST7789-style LCD SPI link.
// Decodes command/parameter bytes, holds the window and mode registers and
// turns RAMWR data into addressed RGB565 pixel writes.
// Ports:
//   clk, resetn   system clock (sclk <= clk/4), async active-low reset
//   spi           SPI link, slave side
//   cmd_valid     1-cycle pulse per command byte, cmd_byte holds it
//   pix_valid     1-cycle pulse per pixel with pix_x, pix_y, pix_data
//   sleep_out     set by SLPOUT, cleared by SLPIN
//   disp_on       set by DISPON, cleared by DISPOFF
//   madctl        parameter of MADCTL
//   colmod        parameter of COLMOD (does not affect pixel assembly)
//   frame_err     sticky, cs_n rose mid-byte; cleared only by reset
module lcd_spi_rx
  import lcd_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 9,
  parameter int XE_RST      = 239,
  parameter int YE_RST      = 319
) (
  input  logic              clk,
  input  logic              resetn,
  lcd_spi_rx_if.slave       spi,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] pix_x,
  output logic [ADDR_W-1:0] pix_y,
  output logic [15:0]       pix_data,
  output logic              sleep_out,
  output logic              disp_on,
  output logic [7:0]        madctl,
  output logic [7:0]        colmod,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_XE0 = ADDR_W'(XE_RST);
  localparam logic [ADDR_W-1:0] ADDR_YE0 = ADDR_W'(YE_RST);

  // Window address from a big-endian parameter pair, truncated to ADDR_W.
  function automatic logic [ADDR_W-1:0] win_addr(input logic [7:0] hi,
                                                 input logic [7:0] lo);
    logic [15:0] word;
    word = {hi, lo};
    return word[ADDR_W-1:0];
  endfunction

  logic       byte_rdy_s;
  logic [7:0] rx_byte_s;
  logic       byte_dc_s;
  logic       frame_err_set_s;

  rx_state_e  state_r;
  rx_state_e  state_nxt_s;

  logic [7:0] cmd_r;        // command whose parameters are being collected
  logic [2:0] param_cnt_r;
  logic [7:0] param0_r;
  logic [7:0] param1_r;
  logic [7:0] param2_r;
  logic [7:0] pix_hi_r;

  logic [ADDR_W-1:0] xs_r;
  logic [ADDR_W-1:0] xe_r;
  logic [ADDR_W-1:0] ys_r;
  logic [ADDR_W-1:0] ye_r;
  logic [ADDR_W-1:0] cur_x_r;
  logic [ADDR_W-1:0] cur_y_r;
  logic [ADDR_W-1:0] nxt_x_s;
  logic [ADDR_W-1:0] nxt_y_s;

  logic cmd_evt_s;
  logic dat_evt_s;
  logic param_last_s;

  lcd_spi_rx_byte #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_byte (
    .clk           (clk),
    .resetn        (resetn),
    .spi_sclk      (spi.sclk),
    .spi_cs_n      (spi.cs_n),
    .spi_dc        (spi.dc),
    .spi_mosi      (spi.mosi),
    .byte_rdy      (byte_rdy_s),
    .rx_byte       (rx_byte_s),
    .byte_dc       (byte_dc_s),
    .frame_err_set (frame_err_set_s)
  );

  assign cmd_evt_s    = byte_rdy_s & ~byte_dc_s;
  assign dat_evt_s    = byte_rdy_s & byte_dc_s;
  assign param_last_s = (param_cnt_r == (param_len(cmd_r) - 3'd1));

  // Decoder state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_CMD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a command byte restarts decoding from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (cmd_evt_s) begin
      case (rx_byte_s)
        CMD_CASET, CMD_RASET, CMD_MADCTL, CMD_COLMOD: state_nxt_s = S_PARAM;
        CMD_RAMWR:                                    state_nxt_s = S_PIX_HI;
        CMD_SLPIN, CMD_SLPOUT, CMD_DISPOFF, CMD_DISPON: state_nxt_s = S_CMD;
        default:                                      state_nxt_s = S_SKIP;
      endcase
    end else if (dat_evt_s) begin
      case (state_r)
        S_PARAM: begin
          if (param_last_s) begin
            state_nxt_s = S_CMD;
          end else begin
            state_nxt_s = S_PARAM;
          end
        end
        S_PIX_HI: state_nxt_s = S_PIX_LO;
        S_PIX_LO: state_nxt_s = S_PIX_HI;
        S_CMD:    state_nxt_s = S_CMD;
        S_SKIP:   state_nxt_s = S_SKIP;
        default:  state_nxt_s = S_CMD;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Cursor advance. ">=" also covers a degenerate window (start > end):
  // the cursor sits at the start, which already exceeds the end, so the
  // axis wraps every pixel and behaves as a single column/row.
  always_comb begin
    nxt_x_s = cur_x_r;
    nxt_y_s = cur_y_r;
    if (cur_x_r >= xe_r) begin
      nxt_x_s = xs_r;
      if (cur_y_r >= ye_r) begin
        nxt_y_s = ys_r;
      end else begin
        nxt_y_s = cur_y_r + ADDR_ONE;
      end
    end else begin
      nxt_x_s = cur_x_r + ADDR_ONE;
      nxt_y_s = cur_y_r;
    end
  end

  // Command decode, parameter collection, window registers and pixel output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'h00;
      pix_valid   <= 1'b0;
      pix_x       <= {ADDR_W{1'b0}};
      pix_y       <= {ADDR_W{1'b0}};
      pix_data    <= 16'h0000;
      sleep_out   <= 1'b0;
      disp_on     <= 1'b0;
      madctl      <= 8'h00;
      colmod      <= 8'h66;
      frame_err   <= 1'b0;
      cmd_r       <= 8'h00;
      param_cnt_r <= 3'd0;
      param0_r    <= 8'h00;
      param1_r    <= 8'h00;
      param2_r    <= 8'h00;
      pix_hi_r    <= 8'h00;
      xs_r        <= {ADDR_W{1'b0}};
      xe_r        <= ADDR_XE0;
      ys_r        <= {ADDR_W{1'b0}};
      ye_r        <= ADDR_YE0;
      cur_x_r     <= {ADDR_W{1'b0}};
      cur_y_r     <= {ADDR_W{1'b0}};
    end else begin
      cmd_valid <= 1'b0;
      pix_valid <= 1'b0;
      if (frame_err_set_s) begin
        frame_err <= 1'b1;
      end
      if (cmd_evt_s) begin
        cmd_valid   <= 1'b1;
        cmd_byte    <= rx_byte_s;
        cmd_r       <= rx_byte_s;
        param_cnt_r <= 3'd0;
        case (rx_byte_s)
          CMD_SLPIN:   sleep_out <= 1'b0;
          CMD_SLPOUT:  sleep_out <= 1'b1;
          CMD_DISPOFF: disp_on   <= 1'b0;
          CMD_DISPON:  disp_on   <= 1'b1;
          CMD_RAMWR: begin
            cur_x_r <= xs_r;
            cur_y_r <= ys_r;
          end
          default: ;
        endcase
      end else if (dat_evt_s) begin
        case (state_r)
          S_PARAM: begin
            param_cnt_r <= param_cnt_r + 3'd1;
            if (param_last_s) begin
              // Whole list received: commit everything at once so an
              // aborted list never leaves a half-updated window.
              case (cmd_r)
                CMD_CASET: begin
                  xs_r <= win_addr(param0_r, param1_r);
                  xe_r <= win_addr(param2_r, rx_byte_s);
                end
                CMD_RASET: begin
                  ys_r <= win_addr(param0_r, param1_r);
                  ye_r <= win_addr(param2_r, rx_byte_s);
                end
                CMD_MADCTL: madctl <= rx_byte_s;
                CMD_COLMOD: colmod <= rx_byte_s;
                default: ;
              endcase
            end else begin
              case (param_cnt_r)
                3'd0:    param0_r <= rx_byte_s;
                3'd1:    param1_r <= rx_byte_s;
                3'd2:    param2_r <= rx_byte_s;
                default: ;
              endcase
            end
          end
          S_PIX_HI: pix_hi_r <= rx_byte_s;
          S_PIX_LO: begin
            pix_valid <= 1'b1;
            pix_x     <= cur_x_r;
            pix_y     <= cur_y_r;
            pix_data  <= {pix_hi_r, rx_byte_s};
            cur_x_r   <= nxt_x_s;
            cur_y_r   <= nxt_y_s;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: self-checking bench for lcd_spi_rx.
// Drives the SPI link bit by bit, captures cmd/pixel pulses and compares them
// with constants and with a byte-level reference model of the panel.
module tb_lcd_spi_rx;
  import lcd_spi_pkg::*;

  localparam int AW = 9;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  lcd_spi_rx_if spi ();

  logic          cmd_valid, pix_valid, sleep_out, disp_on, frame_err;
  logic [7:0]    cmd_byte, madctl, colmod;
  logic [AW-1:0] pix_x, pix_y;
  logic [15:0]   pix_data;

  lcd_spi_rx #(.SYNC_STAGES(2), .ADDR_W(AW), .XE_RST(239), .YE_RST(319)) dut (
    .clk(clk), .resetn(resetn), .spi(spi.slave),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .sleep_out(sleep_out), .disp_on(disp_on), .madctl(madctl), .colmod(colmod),
    .frame_err(frame_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- capture of DUT pulses ----------------
  typedef struct packed { logic [AW-1:0] x; logic [AW-1:0] y; logic [15:0] d; } pix_t;
  pix_t       got_pix[$];
  logic [7:0] got_cmd[$];

  always @(negedge clk) begin
    if (pix_valid) got_pix.push_back({pix_x, pix_y, pix_data});
    if (cmd_valid) got_cmd.push_back(cmd_byte);
  end

  // ---------------- reference model (byte stream level) ----------------
  bit         m_sleep, m_disp;
  logic [7:0] m_madctl, m_colmod, m_cmd_byte;
  int         m_xs, m_xe, m_ys, m_ye;
  int         m_last;        // last command, -1 before any
  logic [7:0] m_q[$];        // bytes received since that command
  int         m_n;           // pixel index since RAMWR
  pix_t       exp_pix[$];
  logic [7:0] exp_cmd[$];

  function automatic int need(int c);
    if (c == int'(CMD_CASET) || c == int'(CMD_RASET)) return 4;
    if (c == int'(CMD_MADCTL) || c == int'(CMD_COLMOD)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_sleep = 1'b0; m_disp = 1'b0; m_madctl = 8'h00; m_colmod = 8'h66;
    m_cmd_byte = 8'h00;
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
    m_last = -1; m_q.delete(); m_n = 0;
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] b);
    int w, h, x, y;
    if (!dc) begin
      exp_cmd.push_back(b);
      m_cmd_byte = b; m_last = int'(b); m_q.delete(); m_n = 0;
      if (b == CMD_SLPIN)   m_sleep = 1'b0;
      if (b == CMD_SLPOUT)  m_sleep = 1'b1;
      if (b == CMD_DISPOFF) m_disp  = 1'b0;
      if (b == CMD_DISPON)  m_disp  = 1'b1;
    end else if (m_last == int'(CMD_RAMWR)) begin
      m_q.push_back(b);
      if (m_q.size() == 2) begin
        w = (m_xs > m_xe) ? 1 : (m_xe - m_xs + 1);
        h = (m_ys > m_ye) ? 1 : (m_ye - m_ys + 1);
        x = m_xs + (m_n % w);
        y = m_ys + ((m_n / w) % h);
        exp_pix.push_back({AW'(x), AW'(y), m_q[0], m_q[1]});
        m_n++;
        m_q.delete();
      end
    end else if (m_q.size() < need(m_last)) begin
      m_q.push_back(b);
      if (m_q.size() == need(m_last)) begin
        if (m_last == int'(CMD_CASET)) begin
          m_xs = int'({m_q[0], m_q[1]}) % 512; m_xe = int'({m_q[2], m_q[3]}) % 512;
        end
        if (m_last == int'(CMD_RASET)) begin
          m_ys = int'({m_q[0], m_q[1]}) % 512; m_ye = int'({m_q[2], m_q[3]}) % 512;
        end
        if (m_last == int'(CMD_MADCTL)) m_madctl = m_q[0];
        if (m_last == int'(CMD_COLMOD)) m_colmod = m_q[0];
      end
    end
  endtask

  // ---------------- SPI driver ----------------
  task automatic send_byte(input bit dc, input logic [7:0] b);
    spi.dc = dc;
    for (int i = 7; i >= 0; i--) begin
      spi.mosi = b[i];
      #40 spi.sclk = 1'b1;
      #40 spi.sclk = 1'b0;
    end
    model_byte(dc, b);
  endtask

  task automatic cmd(input logic [7:0] b);  send_byte(1'b0, b); endtask
  task automatic dat(input logic [7:0] b);  send_byte(1'b1, b); endtask

  task automatic pixel(input logic [15:0] p);
    dat(p[15:8]);
    dat(p[7:0]);
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_npix"}, got_pix.size(), exp_pix.size());
    for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
      check($sformatf("%s_pix%0d_x", tag, i), 32'(got_pix[i].x), 32'(exp_pix[i].x));
      check($sformatf("%s_pix%0d_y", tag, i), 32'(got_pix[i].y), 32'(exp_pix[i].y));
      check($sformatf("%s_pix%0d_d", tag, i), 32'(got_pix[i].d), 32'(exp_pix[i].d));
    end
    check({tag, "_ncmd"}, got_cmd.size(), exp_cmd.size());
    for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), 32'(got_cmd[i]), 32'(exp_cmd[i]));
    got_pix.delete(); exp_pix.delete(); got_cmd.delete(); exp_cmd.delete();
  endtask

  task automatic check_pix(input string tag, input int i, input int x, input int y, input logic [15:0] d);
    if (i < got_pix.size()) begin
      check($sformatf("%s_x%0d", tag, i), 32'(got_pix[i].x), 32'(x));
      check($sformatf("%s_y%0d", tag, i), 32'(got_pix[i].y), 32'(y));
      check($sformatf("%s_d%0d", tag, i), 32'(got_pix[i].d), 32'(d));
    end else begin
      check($sformatf("%s_present%0d", tag, i), 32'(got_pix.size()), 32'(i + 1));
    end
  endtask

  task automatic rand_window(input logic [7:0] c);
    int a, w, e, np;
    logic [15:0] s_w, e_w;
    logic [7:0]  pb[4];
    a = $urandom_range(0, 511);
    w = $urandom_range(0, 4);
    if (w == 4) e = (a == 0) ? 0 : a - 1;          // degenerate window
    else        e = (a + w > 511) ? 511 : a + w;
    s_w = {7'($urandom), 9'(a)};                    // junk above ADDR_W
    e_w = {7'($urandom), 9'(e)};
    pb[0] = s_w[15:8]; pb[1] = s_w[7:0]; pb[2] = e_w[15:8]; pb[3] = e_w[7:0];
    np = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : 4;
    cmd(c);
    for (int k = 0; k < np; k++) dat(pb[k]);
  endtask

  typedef struct { logic [7:0] c; bit sleep; bit disp; } flag_vec_t;
  flag_vec_t tbl[6];

  initial begin
    tbl[0] = '{CMD_SLPOUT,  1'b1, 1'b0};
    tbl[1] = '{CMD_DISPON,  1'b1, 1'b1};
    tbl[2] = '{CMD_DISPOFF, 1'b1, 1'b0};
    tbl[3] = '{CMD_SLPIN,   1'b0, 1'b0};
    tbl[4] = '{CMD_SLPOUT,  1'b1, 1'b0};
    tbl[5] = '{CMD_DISPON,  1'b1, 1'b1};

    spi.sclk = 1'b0; spi.cs_n = 1'b1; spi.dc = 1'b0; spi.mosi = 1'b0;
    resetn = 1'b0;
    model_reset();
    #31;
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_byte",  cmd_byte, 8'h00);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_pix_x",     pix_x, 9'd0);
    check("rst_pix_y",     pix_y, 9'd0);
    check("rst_pix_data",  pix_data, 16'h0000);
    check("rst_sleep",     sleep_out, 1'b0);
    check("rst_disp",      disp_on, 1'b0);
    check("rst_madctl",    madctl, 8'h00);
    check("rst_colmod",    colmod, 8'h66);
    check("rst_frame_err", frame_err, 1'b0);
    resetn = 1'b1;
    #20 spi.cs_n = 1'b0;
    #40;

    // Flag commands, table driven.
    for (int i = 0; i < 6; i++) begin
      cmd(tbl[i].c);
      settle();
      check($sformatf("flag%0d_sleep", i), sleep_out, tbl[i].sleep);
      check($sformatf("flag%0d_disp", i),  disp_on,   tbl[i].disp);
      check($sformatf("flag%0d_cmd", i),   cmd_byte,  tbl[i].c);
      check($sformatf("flag%0d_pulses", i), got_cmd.size(), 1);
      got_cmd.delete(); exp_cmd.delete();
    end

    // Mode registers.
    cmd(CMD_MADCTL); dat(8'hA5);
    cmd(CMD_COLMOD); dat(8'h55);
    settle();
    check("madctl", madctl, 8'hA5);
    check("colmod", colmod, 8'h55);
    compare_model("mode");

    // Window setup and write.
    cmd(CMD_CASET); dat(8'h00); dat(8'h28); dat(8'h01); dat(8'h17);
    cmd(CMD_RASET); dat(8'h00); dat(8'h35); dat(8'h00); dat(8'hBB);
    cmd(CMD_RAMWR);
    pixel(16'hF800); pixel(16'h07E0); pixel(16'h001F); pixel(16'hFFFF);
    settle();
    check("win_npix", got_pix.size(), 4);
    check_pix("win", 0, 40, 53, 16'hF800);
    check_pix("win", 1, 41, 53, 16'h07E0);
    check_pix("win", 2, 42, 53, 16'h001F);
    check_pix("win", 3, 43, 53, 16'hFFFF);
    compare_model("win");

    // 2x2 window, frame wrap.
    cmd(CMD_CASET); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
    cmd(CMD_RASET); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
    cmd(CMD_RAMWR);
    for (int i = 0; i < 5; i++) pixel(16'h1000 + 16'(i));
    settle();
    check_pix("wrap", 0, 0, 0, 16'h1000);
    check_pix("wrap", 1, 1, 0, 16'h1001);
    check_pix("wrap", 2, 0, 1, 16'h1002);
    check_pix("wrap", 3, 1, 1, 16'h1003);
    check_pix("wrap", 4, 0, 0, 16'h1004);
    compare_model("wrap");

    // Aborted CASET leaves the window alone.
    cmd(CMD_DISPOFF);
    cmd(CMD_CASET); dat(8'h00); dat(8'h05);
    cmd(CMD_DISPON);
    cmd(CMD_RAMWR); pixel(16'hABCD); pixel(16'h1234);
    settle();
    check("abort_disp", disp_on, 1'b1);
    check_pix("abort", 0, 0, 0, 16'hABCD);
    check_pix("abort", 1, 1, 0, 16'h1234);
    compare_model("abort");

    // Half pixel aborted by a new RAMWR.
    cmd(CMD_RAMWR); dat(8'h77); cmd(CMD_RAMWR);
    settle();
    check("halfpix_none", got_pix.size(), 0);
    pixel(16'h5A5A);
    settle();
    check_pix("halfpix", 0, 0, 0, 16'h5A5A);
    compare_model("halfpix");

    // Framing error: cs_n rises after 5 bits.
    cmd(CMD_SLPIN);
    spi.dc = 1'b0;
    for (int i = 7; i >= 3; i--) begin
      spi.mosi = CMD_SLPOUT[i];
      #40 spi.sclk = 1'b1;
      #40 spi.sclk = 1'b0;
    end
    #40 spi.cs_n = 1'b1;
    #80;
    settle();
    check("ferr_set", frame_err, 1'b1);
    check("ferr_sleep_kept", sleep_out, 1'b0);
    spi.cs_n = 1'b0;
    #40;
    cmd(CMD_SLPOUT);
    settle();
    check("ferr_next_sleep", sleep_out, 1'b1);
    check("ferr_next_cmd", cmd_byte, CMD_SLPOUT);
    check("ferr_sticky", frame_err, 1'b1);
    compare_model("ferr");

    // Unknown command with parameters.
    cmd(8'hB2); dat(8'h0C); dat(8'h0C); dat(8'h00); dat(8'h33); dat(8'h33);
    settle();
    check("unk_cmd", cmd_byte, 8'hB2);
    check("unk_npix", got_pix.size(), 0);
    check("unk_madctl", madctl, 8'hA5);
    check("unk_colmod", colmod, 8'h55);
    check("unk_sleep", sleep_out, 1'b1);
    check("unk_disp", disp_on, 1'b1);
    cmd(CMD_RAMWR); pixel(16'h0F0F);
    settle();
    check_pix("unk", 0, 0, 0, 16'h0F0F);
    compare_model("unk");

    // Randomized traffic against the model.
    for (int it = 0; it < 100; it++) begin
      int kind, n;
      kind = $urandom_range(0, 8);
      case (kind)
        0: rand_window(CMD_CASET);
        1: rand_window(CMD_RASET);
        2, 3: begin
          cmd(CMD_RAMWR);
          n = $urandom_range(0, 13);
          for (int k = 0; k < n; k++) dat(8'($urandom));
        end
        4: begin cmd(CMD_MADCTL); dat(8'($urandom)); end
        5: begin cmd(CMD_COLMOD); dat(8'($urandom)); end
        6: begin
          n = $urandom_range(0, 3);
          cmd(n == 0 ? CMD_SLPIN : n == 1 ? CMD_SLPOUT : n == 2 ? CMD_DISPOFF : CMD_DISPON);
        end
        7: begin
          cmd(8'($urandom));
          n = $urandom_range(0, 3);
          for (int k = 0; k < n; k++) dat(8'($urandom));
        end
        default: begin
          spi.cs_n = 1'b1;
          #80 spi.cs_n = 1'b0;
          #40;
        end
      endcase
      if (it % 20 == 19) begin
        settle();
        compare_model($sformatf("rnd%0d", it));
      end
    end
    settle();
    compare_model("rnd_end");
    check("rnd_sleep",  sleep_out, m_sleep);
    check("rnd_disp",   disp_on,   m_disp);
    check("rnd_madctl", madctl,    m_madctl);
    check("rnd_colmod", colmod,    m_colmod);
    check("rnd_cmd",    cmd_byte,  m_cmd_byte);
    check("rnd_ferr",   frame_err, 1'b1);

    // Reset mid-byte returns everything to reset values.
    spi.dc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      spi.mosi = 1'b1;
      #40 spi.sclk = 1'b1;
      #40 spi.sclk = 1'b0;
    end
    resetn = 1'b0;
    #20;
    check("rst2_ferr",   frame_err, 1'b0);
    check("rst2_colmod", colmod, 8'h66);
    check("rst2_sleep",  sleep_out, 1'b0);
    resetn = 1'b1;
    model_reset();
    got_pix.delete(); got_cmd.delete(); exp_pix.delete(); exp_cmd.delete();
    #40;
    cmd(CMD_RAMWR); pixel(16'hC0DE);
    settle();
    check_pix("rst2", 0, 0, 0, 16'hC0DE);
    check("rst2_ferr_clean", frame_err, 1'b0);
    compare_model("rst2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lcd_spi_rx.md
Name: lcd_spi_rx

Overview:
- Receive side of the 4-wire ST7789-style LCD SPI link (sclk, cs_n, dc, mosi), oversampled in the clk domain.
- Decodes command/parameter bytes, keeps the panel's window and mode registers, and turns RAMWR data into addressed 16-bit pixel writes.
- Acts as a synthesizable panel model and capture front-end, so the LCD driver can be looped back on-board or checked in simulation without a physical display.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on all four SPI inputs (must be at least 2).
- ADDR_W, 9, width of column/row addresses.
- XE_RST, 239, reset value of the column end address.
- YE_RST, 319, reset value of the row end address.

Ports:
- clk  in  1  system clock; sclk must be at most clk/4.
- resetn  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  SPI clock, mode 0, MSB first.
- spi_cs_n  in  1  chip select, active low.
- spi_dc  in  1  0 = command byte, 1 = data/parameter byte.
- spi_mosi  in  1  serial data.
- cmd_valid  out  1  one-cycle pulse per completed command byte.
- cmd_byte  out  8  last command byte.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_x  out  ADDR_W  column of the pixel.
- pix_y  out  ADDR_W  row of the pixel.
- pix_data  out  16  RGB565 pixel value, high byte first on the wire.
- sleep_out  out  1  set by 0x11, cleared by 0x10.
- disp_on  out  1  set by 0x29, cleared by 0x28.
- madctl  out  8  parameter of 0x36.
- colmod  out  8  parameter of 0x3A.
- frame_err  out  1  sticky; set when cs_n rises mid-byte; cleared only by reset.

Behaviour:
- Reset values:
  - All outputs 0, except: frame_err 0, madctl 0x00, colmod 0x66.
  - Window: xs 0, xe XE_RST, ys 0, ye YE_RST.
  - FSM in S_CMD.
- Input front end:
  - SYNC_STAGES flops on every SPI input.
  - A rising edge of synchronized sclk with cs_n low shifts mosi into the LSB of the shift register.
  - spi_dc is captured together with the 8th bit.
- Byte framing:
  - After 8 bits, byte_rdy pulses for 1 cycle and the bit counter returns to 0.
  - cs_n high clears the bit counter and discards any partial byte.
  - A partial byte (count 1..7) discarded this way sets frame_err.
  - cs_n toggling between whole bytes is legal and does not change FSM state.
- Byte FSM states: S_CMD, S_PARAM, S_PIX_HI, S_PIX_LO, S_SKIP.
- Command byte (dc=0): accepted from every state; aborts any partial parameter list or half pixel.
  - Pulses cmd_valid and updates cmd_byte one cycle after byte_rdy.
  - 0x2A or 0x2B: go to S_PARAM expecting 4 bytes.
  - 0x36 or 0x3A: go to S_PARAM expecting 1 byte.
  - 0x2C: load cursor x←xs, y←ys, then go to S_PIX_HI.
  - 0x10, 0x11, 0x28, 0x29: update the flag immediately, then go to S_CMD.
  - Any other command: go to S_SKIP.
- S_PARAM:
  - Bytes are collected in order.
  - 0x2A applies xs = {p0,p1}[ADDR_W-1:0] and xe = {p2,p3}[ADDR_W-1:0].
  - 0x2B applies ys and ye the same way.
  - Values are applied atomically only when the last byte arrives; an aborted list leaves the registers unchanged.
  - After the last byte, go to S_CMD; further data bytes are ignored.
- S_PIX_HI: latch the high byte, go to S_PIX_LO.
- S_PIX_LO:
  - Pulse pix_valid the cycle after byte_rdy (latency 1) with the current cursor and {hi,lo}.
  - Then advance the cursor:
    - x==xe: x←xs and y advances.
    - y==ye at that moment: y←ys (frame wrap).
  - Return to S_PIX_HI.
- Data bytes in S_CMD or S_SKIP: dropped.
- Degenerate windows:
  - xs>xe: treat as a single column (x stays at xs, y advances each pixel).
  - ys>ye: same rule for rows.
- colmod value does not change pixel assembly (always 2 bytes per pixel).
- Reset mid-transfer: immediate return to the reset values; the bit counter is cleared.

Decomposition:
- Shared package lcd_spi_pkg:
  - Command opcodes: CMD_SLPIN, CMD_SLPOUT, CMD_DISPOFF, CMD_DISPON, CMD_CASET, CMD_RASET, CMD_RAMWR, CMD_MADCTL, CMD_COLMOD.
  - Byte-FSM state encoding.
  - The opcodes are also used by the driver.
- Sub-module lcd_spi_rx_byte: synchronizers, edge detect, shift register and bit counter; outputs byte_rdy, byte, byte_dc, frame_err_set.

Test Plan:
- Wake and display on: send 0x11, then 0x29 -> sleep_out=1, disp_on=1, cmd_valid pulses twice, cmd_byte=0x29.
- Window setup and write:
  - Send 0x2A 00 28 01 17, then 0x2B 00 35 00 BB, then 0x2C, then 4 pixels F800,07E0,001F,FFFF.
  - Required: writes at (40,53), (41,53), (42,53), (43,53) with matching data.
- Wrap:
  - Window 0x2A 00 00 00 01, 0x2B 00 00 00 01, then 0x2C and 5 pixels.
  - Required coordinates: (0,0), (1,0), (0,1), (1,1), (0,0).
- Abort:
  - Send 0x2A 00 05 then 0x29 -> xs/xe unchanged, disp_on=1.
  - Send 0x2C, one byte, then 0x2C -> no pix_valid.
- Framing error: raise cs_n after 5 bits -> frame_err=1, next full 0x11 still decoded.
- Unknown command: send 0xB2 0C 0C 00 33 33 -> cmd_byte=0xB2, no register or pixel changes.
